// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
package memory_arbiter_pkg;

  localparam int BUS_ADDR_WIDTH = 24;
  localparam int BUS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_DONE   = 2'd2
  } state_e;

  // Round-robin: on contention the requester that was not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) begin
      return ~last_grant;
    end
    return req1 & ~req0;
  endfunction

endpackage

// File: rtl/arbiter_timeout.sv
// Watchdog counter for stalled bus accesses; tc_o flags the last allowed ACCESS cycle.
module arbiter_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [15:0] TC_VALUE = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VALUE);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory_bus port between CPU (0) and DMA (1); every output is registered.
// Define MEMORY_ARBITER_CPU_PRIORITY_EN to make the CPU win all simultaneous requests.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_0,
  input  logic                      req_1,
  input  logic                      we_0,
  input  logic                      we_1,
  input  logic [BUS_ADDR_WIDTH-1:0] addr_0,
  input  logic [BUS_ADDR_WIDTH-1:0] addr_1,
  input  logic [BUS_DATA_WIDTH-1:0] wdata_0,
  input  logic [BUS_DATA_WIDTH-1:0] wdata_1,
  output logic                      ack_0,
  output logic                      ack_1,
  output logic [BUS_DATA_WIDTH-1:0] rdata,
  output logic                      error,
  output logic                      busy,
  output logic [BUS_ADDR_WIDTH-1:0] bus_address,
  output logic [BUS_DATA_WIDTH-1:0] bus_data_out,
  output logic                      bus_enable,
  output logic                      bus_write_enable,
  input  logic [BUS_DATA_WIDTH-1:0] bus_data_in,
  input  logic                      bus_halt
);

  state_e                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_grant_q, last_grant_d;
  logic                      we_q, we_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      bus_en_q, bus_en_d;
  logic                      bus_we_q, bus_we_d;
  logic [1:0]                ack_q, ack_d;
  logic                      error_q, error_d;
  logic                      busy_q, busy_d;
  logic                      winner;
  logic                      cnt_clr, cnt_en, cnt_tc;

`ifdef MEMORY_ARBITER_CPU_PRIORITY_EN
  assign winner = ~req_0;
`else
  assign winner = rr_pick(req_0, req_1, last_grant_q);
`endif

  arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst_n(reset),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    bus_en_d     = 1'b0;
    bus_we_d     = 1'b0;
    ack_d        = 2'b00;
    error_d      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        if (req_0 || req_1) begin
          grant_d  = winner;
          we_d     = winner ? we_1 : we_0;
          addr_d   = winner ? addr_1 : addr_0;
          wdata_d  = winner ? wdata_1 : wdata_0;
          cnt_clr  = 1'b1;
          bus_en_d = 1'b1;
          bus_we_d = winner ? we_1 : we_0;
          state_d  = STATE_ACCESS;
        end
      end
      STATE_ACCESS: begin
        if (!bus_halt) begin
          if (!we_q) begin
            rdata_d = bus_data_in;
          end
          ack_d[grant_q] = 1'b1;
          state_d        = STATE_DONE;
        end else if (cnt_tc) begin
          ack_d[grant_q] = 1'b1;
          error_d        = 1'b1;
          state_d        = STATE_DONE;
        end else begin
          cnt_en   = 1'b1;
          bus_en_d = 1'b1;
          bus_we_d = we_q;
        end
      end
      STATE_DONE: begin
        last_grant_d = grant_q;
        state_d      = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase

    busy_d = (state_d != STATE_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= STATE_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      bus_en_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      ack_q        <= 2'b00;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      bus_en_q     <= bus_en_d;
      bus_we_q     <= bus_we_d;
      ack_q        <= ack_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_0            = ack_q[0];
  assign ack_1            = ack_q[1];
  assign error            = error_q;
  assign busy             = busy_q;
  assign rdata            = rdata_q;
  assign bus_address      = addr_q;
  assign bus_data_out     = wdata_q;
  assign bus_enable       = bus_en_q;
  assign bus_write_enable = bus_we_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level model plus directed and random traffic.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
  logic [23:0] addr_0 = '0, addr_1 = '0;
  logic [7:0]  wdata_0 = '0, wdata_1 = '0;
  logic [7:0]  bus_data_in = '0;
  logic        bus_halt = 1'b0;
  logic        ack_0, ack_1, error, busy, bus_enable, bus_write_enable;
  logic [7:0]  rdata, bus_data_out;
  logic [23:0] bus_address;

  int passed = 0;
  int total  = 0;

  memory_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata), .error(error), .busy(busy),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable),
    .bus_data_in(bus_data_in), .bus_halt(bus_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit pick(input bit r0, input bit r1, input bit last);
`ifdef MEMORY_ARBITER_CPU_PRIORITY_EN
    return !r0;
`else
    return (r0 && r1) ? !last : !r0;
`endif
  endfunction

  // Transaction model: one access in flight, counted in bus cycles, then an ack cycle.
  bit          m_active, m_done, m_err, m_who, m_last, m_we;
  int          m_n;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 0; m_done <= 0; m_err <= 0; m_who <= 0; m_last <= 1; m_we <= 0;
      m_n <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_done) begin
      m_done <= 0;
      m_err  <= 0;
      m_last <= m_who;
    end else if (m_active) begin
      m_n <= m_n + 1;
      if (!bus_halt) begin
        if (!m_we) m_rdata <= bus_data_in;
        m_active <= 0; m_done <= 1; m_err <= 0;
      end else if (m_n + 1 == T) begin
        m_active <= 0; m_done <= 1; m_err <= 1;
      end
    end else if (req_0 || req_1) begin
      bit w;
      w = pick(req_0, req_1, m_last);
      m_who    <= w;
      m_we     <= w ? we_1 : we_0;
      m_addr   <= w ? addr_1 : addr_0;
      m_wdata  <= w ? wdata_1 : wdata_0;
      m_active <= 1;
      m_n      <= 0;
    end
  end

  always @(negedge clk) begin
    check("busy",             busy,             m_active | m_done);
    check("bus_enable",       bus_enable,       m_active);
    check("bus_write_enable", bus_write_enable, m_active & m_we);
    check("ack_0",            ack_0,            m_done & !m_who);
    check("ack_1",            ack_1,            m_done & m_who);
    check("error",            error,            m_done & m_err);
    check("rdata",            rdata,            m_rdata);
    check("bus_address",      bus_address,      m_addr);
    check("bus_data_out",     bus_data_out,     m_wdata);
  end

  // Waits for the ack of requester 'who'; bus_halt falls (with late_data) at negedge halt_low_at.
  task automatic run_access(input bit who, input int halt_low_at, input logic [7:0] late_data,
                            output int lat, output int en, output bit err);
    lat = -1; en = 0; err = 0;
    bus_halt = (halt_low_at > 0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus_enable) en++;
      if ((who ? ack_1 : ack_0) === 1'b1) begin
        lat = n;
        err = error;
        if (who) req_1 = 0; else req_0 = 0;
        break;
      end
      if (n == halt_low_at) begin
        bus_halt    = 0;
        bus_data_in = late_data;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, en, stuck, got;
    bit err;
    int g[4];
    int exp_g[4];

    #1 reset = 0;
    @(negedge clk);
    check("rst_bus_enable", bus_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack_1, ack_0}, 0);
    check("rst_error", error, 0);
    check("rst_address", bus_address, 0);
    check("rst_rdata", rdata, 0);
    #2 reset = 1;

    // Single read
    @(negedge clk);
    req_0 = 1; we_0 = 0; addr_0 = 24'h008010; bus_data_in = 8'h5A; bus_halt = 0;
    @(negedge clk);
    check("rd_enable", bus_enable, 1);
    check("rd_address", bus_address, 24'h008010);
    check("rd_write_enable", bus_write_enable, 0);
    @(negedge clk);
    check("rd_ack0", ack_0, 1);
    check("rd_data", rdata, 8'h5A);
    check("rd_error", error, 0);
    req_0 = 0;

    // Single write
    @(negedge clk);
    req_1 = 1; we_1 = 1; addr_1 = 24'h008123; wdata_1 = 8'hC3; bus_data_in = 8'h11;
    @(negedge clk);
    check("wr_enable", bus_enable, 1);
    check("wr_write_enable", bus_write_enable, 1);
    check("wr_data_out", bus_data_out, 8'hC3);
    @(negedge clk);
    check("wr_ack1", ack_1, 1);
    check("wr_rdata_kept", rdata, 8'h5A);
    req_1 = 0;

    // Contention
    @(negedge clk);
    req_0 = 1; req_1 = 1;
    we_0 = 1'($urandom_range(0, 1)); addr_0 = 24'($urandom); wdata_0 = 8'($urandom);
    we_1 = 1'($urandom_range(0, 1)); addr_1 = 24'($urandom); wdata_1 = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int n = 0; n < 20 && got < 0; n++) begin
        @(negedge clk);
        if (ack_0) got = 0;
        else if (ack_1) got = 1;
      end
      g[k] = got;
      if (got == 0) req_0 = 0;
      else if (got == 1) req_1 = 0;
      if (k == 3) begin
        req_0 = 0; req_1 = 0;
      end else begin
        @(negedge clk);
        if (got == 0) begin req_0 = 1; addr_0 = 24'($urandom); end
        else if (got == 1) begin req_1 = 1; addr_1 = 24'($urandom); end
      end
    end
`ifdef MEMORY_ARBITER_CPU_PRIORITY_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++) check($sformatf("contention_grant%0d", k), g[k], exp_g[k]);

    // Halt stretch: bus_halt high for 5 ACCESS cycles
    @(negedge clk);
    req_0 = 1; we_0 = 0; addr_0 = 24'h010000; bus_data_in = 8'hEE;
    run_access(0, 6, 8'h77, lat, en, err);
    check("halt_latency", lat, 7);
    check("halt_enable_cycles", en, 6);
    check("halt_rdata", rdata, 8'h77);
    check("halt_error", err, 0);

    // Timeout with bus_halt stuck high
    @(negedge clk);
    req_0 = 1; we_0 = 0; addr_0 = 24'h000200; bus_data_in = 8'h99;
    run_access(0, 1000, 8'h00, lat, en, err);
    check("to_enable_cycles", en, T);
    check("to_latency", lat, T + 1);
    check("to_error", err, 1);
    check("to_rdata_kept", rdata, 8'h77);
    bus_halt = 0;
    @(negedge clk);
    req_0 = 1; we_0 = 0; addr_0 = 24'h000201; bus_data_in = 8'h12;
    run_access(0, 0, 8'h00, lat, en, err);
    check("post_to_latency", lat, 2);
    check("post_to_error", err, 0);
    check("post_to_rdata", rdata, 8'h12);

    // Reset in the 3rd ACCESS cycle
    @(negedge clk);
    req_0 = 1; we_0 = 0; addr_0 = 24'h000300; bus_halt = 1;
    repeat (3) @(negedge clk);
    check("mrst_pre_enable", bus_enable, 1);
    #2 reset = 0;
    #1;
    check("mrst_enable_drop", bus_enable, 0);
    check("mrst_busy_drop", busy, 0);
    req_0 = 0; bus_halt = 0;
    @(negedge clk);
    check("mrst_no_ack", {ack_1, ack_0}, 0);
    #2 reset = 1;
    @(negedge clk);
    req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; bus_data_in = 8'h3C;
    addr_0 = 24'h000400; addr_1 = 24'h000500;
    run_access(0, 0, 8'h00, lat, en, err);
    check("mrst_first_grant0_latency", lat, 2);
    check("mrst_rdata", rdata, 8'h3C);
    run_access(1, 0, 8'h00, lat, en, err);
    check("mrst_then_grant1_latency", lat, 3);

    // Random traffic
    stuck = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (req_0 && ack_0) req_0 = 0;
      else if (!req_0 && $urandom_range(0, 3) == 0) begin
        req_0 = 1; we_0 = 1'($urandom_range(0, 1));
        addr_0 = 24'($urandom); wdata_0 = 8'($urandom);
      end
      if (req_1 && ack_1) req_1 = 0;
      else if (!req_1 && $urandom_range(0, 3) == 0) begin
        req_1 = 1; we_1 = 1'($urandom_range(0, 1));
        addr_1 = 24'($urandom); wdata_1 = 8'($urandom);
      end
      if (stuck > 0) begin
        bus_halt = 1; stuck--;
      end else if ($urandom_range(0, 49) == 0) begin
        bus_halt = 1; stuck = T + 2;
      end else begin
        bus_halt = ($urandom_range(0, 2) == 0);
      end
      bus_data_in = 8'($urandom);
    end

    req_0 = 0; req_1 = 0; bus_halt = 0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
